// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and the vertical-phase state type.
// Optional frame counter (VTIMING_FRAME_CNT_EN) is handled in v_timing_gen.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam logic SYNC_ACTIVE = 1'b0;

    // Boundaries sized to the 16-bit count buses so comparisons stay width-exact.
    localparam logic [15:0] H_ACTIVE_W   = 16'(H_ACTIVE);
    localparam logic [15:0] H_SYNC_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SYNC_END   = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [15:0] H_TOTAL      = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);

    localparam logic [15:0] V_TOTAL      = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [15:0] V_ACT_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] V_FP_LAST    = 16'(V_ACTIVE + V_FP - 1);
    localparam logic [15:0] V_SYNC_LAST  = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [15:0] V_LAST       = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {VAct, VFp, VSync, VBp} v_state_e;

endpackage

// File: rtl/v_timing_gen_if.sv
// Bus between the horizontal counter / pixel renderer and v_timing_gen.
// frame_count exists only when VTIMING_FRAME_CNT_EN is defined.
interface v_timing_gen_if;

    logic        enable_V_Counter;
    logic [15:0] H_Count_Value;
    logic [15:0] V_Count_Value;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_start;
`ifdef VTIMING_FRAME_CNT_EN
    logic [7:0]  frame_count;

    modport master (
        output enable_V_Counter, H_Count_Value,
        input  V_Count_Value, hsync, vsync, video_on, pixel_x, pixel_y, frame_start, frame_count
    );
    modport slave (
        input  enable_V_Counter, H_Count_Value,
        output V_Count_Value, hsync, vsync, video_on, pixel_x, pixel_y, frame_start, frame_count
    );
`else
    modport master (
        output enable_V_Counter, H_Count_Value,
        input  V_Count_Value, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
    );
    modport slave (
        input  enable_V_Counter, H_Count_Value,
        output V_Count_Value, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
    );
`endif

endinterface

// File: rtl/v_phase_fsm.sv
// Vertical line counter and phase state machine; both advance only on enable_V_Counter.
// frame_wrap flags the enable edge on which line 524 wraps to 0.
module v_phase_fsm
    import vga_timing_pkg::*;
(
    input  logic        clk_25MHz,
    input  logic        reset,
    input  logic        enable_V_Counter,
    output logic [15:0] v_count,
    output v_state_e    v_state,
    output logic        frame_wrap
);

    logic [15:0] v_count_d;
    v_state_e    v_state_d;

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            v_count <= '0;
            v_state <= VAct;
        end else begin
            v_count <= v_count_d;
            v_state <= v_state_d;
        end
    end

    // State moves on the same edge the count crosses a phase boundary.
    always_comb begin
        v_count_d = v_count;
        v_state_d = v_state;
        if (enable_V_Counter) begin
            v_count_d = (v_count == V_LAST) ? '0 : v_count + 16'd1;
            case (v_state)
                VAct:    if (v_count == V_ACT_LAST)  v_state_d = VFp;
                VFp:     if (v_count == V_FP_LAST)   v_state_d = VSync;
                VSync:   if (v_count == V_SYNC_LAST) v_state_d = VBp;
                VBp:     if (v_count == V_LAST)      v_state_d = VAct;
                default: v_state_d = VAct;
            endcase
        end
    end

    always_comb begin
        frame_wrap = enable_V_Counter && (v_count == V_LAST);
    end

endmodule

// File: rtl/v_timing_gen.sv
// Vertical stage of the VGA timing chain: registered sync, blanking, coordinates, frame pulse.
// Define VTIMING_FRAME_CNT_EN to add the 8-bit wrapping frame_count output.
module v_timing_gen
    import vga_timing_pkg::*;
(
    input  logic           clk_25MHz,
    input  logic           reset,
    v_timing_gen_if.slave  vif
);

    logic [15:0] v_count;
    v_state_e    v_state;
    logic        frame_wrap;

    logic       hsync_d, vsync_d, video_on_d;
    logic [9:0] pixel_x_d, pixel_y_d;
    logic       hsync_q, vsync_q, video_on_q, frame_start_q;
    logic [9:0] pixel_x_q, pixel_y_q;

    v_phase_fsm u_v_phase_fsm (
        .clk_25MHz        (clk_25MHz),
        .reset            (reset),
        .enable_V_Counter (vif.enable_V_Counter),
        .v_count          (v_count),
        .v_state          (v_state),
        .frame_wrap       (frame_wrap)
    );

    // Out-of-range H (>799) falls outside both windows, so it decodes as blanking.
    always_comb begin
        hsync_d    = ((vif.H_Count_Value >= H_SYNC_START) && (vif.H_Count_Value <= H_SYNC_END))
                     ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d    = (v_state == VSync) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        video_on_d = (vif.H_Count_Value < H_ACTIVE_W) && (v_state == VAct);
        pixel_x_d  = video_on_d ? vif.H_Count_Value[9:0] : '0;
        pixel_y_d  = video_on_d ? v_count[9:0] : '0;
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= frame_wrap;
        end
    end

    assign vif.V_Count_Value = v_count;
    assign vif.hsync         = hsync_q;
    assign vif.vsync         = vsync_q;
    assign vif.video_on      = video_on_q;
    assign vif.pixel_x       = pixel_x_q;
    assign vif.pixel_y       = pixel_y_q;
    assign vif.frame_start   = frame_start_q;

`ifdef VTIMING_FRAME_CNT_EN
    logic [7:0] frame_count_q;

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            frame_count_q <= '0;
        end else if (frame_wrap) begin
            frame_count_q <= frame_count_q + 8'd1;
        end
    end

    assign vif.frame_count = frame_count_q;
`endif

endmodule
